// File: rtl/ssm_block_core.sv
// ssm_block_core: Mamba-2 selective-state-space tile core, h_new = dA*h_prev + dt*B*x, y = sum(h_new*C) + D*x.
// Optional macro SSM_HSTATE_OUT_EN adds h_new_o / h_new_valid_o carrying each tile's new state.
module ssm_block_core #(
  parameter int DW        = 16,
  parameter int FRAC      = 8,
  parameter int H_TILE    = 1,
  parameter int P_TILE    = 1,
  parameter int N_TILE    = 128,
  parameter int P_TOTAL   = 64,
  parameter int N_TOTAL   = 128,
  parameter int LAT_DX_M  = 6,
  parameter int LAT_DBX_M = 6,
  parameter int LAT_DAH_M = 6,
  parameter int LAT_HC_M  = 6,
  parameter int LAT_MUL   = 6,
  parameter int LAT_ADD_A = 11,
  parameter int LAT_ACCU  = 77,
  parameter int LAT_ADD   = 11,
  parameter int LAT_DIV   = 15,
  parameter int LAT_EXP   = 60,
  parameter int LAT_SP    = 93
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                tile_valid_i,
  output logic                                tile_ready_o,
  input  logic [H_TILE*DW-1:0]                dt_i,
  input  logic [H_TILE*DW-1:0]                dt_bias_i,
  input  logic [H_TILE*DW-1:0]                A_i,
  input  logic [H_TILE*P_TILE*DW-1:0]         x_i,
  input  logic [H_TILE*DW-1:0]                D_i,
  input  logic [N_TILE*DW-1:0]                B_tile_i,
  input  logic [N_TILE*DW-1:0]                C_tile_i,
  input  logic [H_TILE*P_TILE*N_TILE*DW-1:0]  hprev_tile_i,
  output logic [H_TILE*P_TILE*DW-1:0]         y_final_o,
  output logic                                y_final_valid_o
`ifdef SSM_HSTATE_OUT_EN
  ,
  output logic [H_TILE*P_TILE*N_TILE*DW-1:0]  h_new_o,
  output logic                                h_new_valid_o
`endif
);

  localparam int HP      = H_TILE * P_TILE;
  localparam int NT      = N_TOTAL / N_TILE;
  localparam int AW      = DW + $clog2(N_TOTAL) + 1;
  localparam int WW      = ((AW > 2 * DW) ? AW : 2 * DW) + 2;
  localparam int T_TILE  = LAT_SP + LAT_EXP + LAT_DAH_M + LAT_ADD_A + LAT_HC_M + LAT_ACCU;
  localparam int T_FINAL = LAT_DX_M + LAT_ADD;
  localparam int T_MAX   = (T_TILE > T_FINAL) ? T_TILE : T_FINAL;
  localparam int CNTW    = $clog2(T_MAX + 1);
  localparam int CW      = (NT > 1) ? $clog2(NT) : 1;
  localparam int ONE_I   = 1 << FRAC;
  localparam logic signed [DW-1:0] ONE  = DW'(ONE_I);
  localparam logic signed [WW-1:0] SMAX = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] SMIN = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  if ((N_TOTAL % N_TILE) != 0 || (P_TOTAL % P_TILE) != 0 ||
      LAT_MUL < 0 || LAT_DIV < 0 || LAT_DBX_M < 0) begin : g_bad_cfg
    $error("ssm_block_core: totals must be multiples of tile sizes");
  end

  typedef enum logic [1:0] {IDLE, BUSY, FINAL} state_t;

  state_t                         state, next_state;
  logic [CNTW-1:0]                cnt;
  logic [CW-1:0]                  tile_cnt;
  logic                           accept, busy_done, final_done, last_tile;
  logic [H_TILE*DW-1:0]           dt_r, bias_r, a_r, d_r;
  logic [HP*DW-1:0]               x_r;
  logic [N_TILE*DW-1:0]           b_r, c_r;
  logic [HP*N_TILE*DW-1:0]        hp_r;
  logic signed [AW-1:0]           acc      [HP];
  logic signed [AW-1:0]           tile_sum [HP];
  logic signed [DW-1:0]           y_next   [HP];
`ifdef SSM_HSTATE_OUT_EN
  logic [HP*N_TILE*DW-1:0]        hn_flat;
`endif

  function automatic logic signed [DW-1:0] sat(input logic signed [WW-1:0] v);
    if (v > SMAX)      sat = SMAX[DW-1:0];
    else if (v < SMIN) sat = SMIN[DW-1:0];
    else               sat = v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] mul(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [WW-1:0] p;
    p = (WW'(a) * WW'(b)) >>> FRAC;
    return sat(p);
  endfunction

  assign last_tile = (tile_cnt == CW'(NT - 1));

  // Handshake: a tile transfers on a rising edge where tile_valid_i & tile_ready_o;
  // ready is held low through BUSY/FINAL and during the y_final_valid_o pulse cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    tile_ready_o = 1'b0;
    accept       = 1'b0;
    busy_done    = 1'b0;
    final_done   = 1'b0;
    case (state)
      IDLE: begin
        tile_ready_o = !y_final_valid_o;
        accept       = tile_valid_i && !y_final_valid_o;
        if (accept) next_state = BUSY;
      end
      BUSY: begin
        if (cnt == CNTW'(T_TILE - 1)) begin
          busy_done  = 1'b1;
          next_state = last_tile ? FINAL : IDLE;
        end
      end
      FINAL: begin
        if (cnt == CNTW'(T_FINAL - 1)) begin
          final_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      cnt <= '0;
    else if (accept || busy_done)   cnt <= '0;
    else if (state != IDLE)         cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dt_r <= '0; bias_r <= '0; a_r <= '0; d_r <= '0;
      x_r  <= '0; b_r    <= '0; c_r <= '0; hp_r <= '0;
    end else if (accept) begin
      dt_r <= dt_i; bias_r <= dt_bias_i; a_r <= A_i; d_r <= D_i;
      x_r  <= x_i;  b_r    <= B_tile_i;  c_r <= C_tile_i; hp_r <= hprev_tile_i;
    end
  end

  // Whole-tile arithmetic evaluated from the captured operands; consumed at the end of BUSY.
  always_comb begin : p_datapath
    logic signed [DW-1:0] s_v, dtp_v, da_v, x_v, hn_v;
    logic signed [WW-1:0] t_v;
    int k;
    s_v = '0; dtp_v = '0; da_v = '0; x_v = '0; hn_v = '0; t_v = '0; k = 0;
    for (int i = 0; i < HP; i++) begin
      tile_sum[i] = '0;
      y_next[i]   = '0;
    end
`ifdef SSM_HSTATE_OUT_EN
    hn_flat = '0;
`endif
    for (int h = 0; h < H_TILE; h++) begin
      s_v   = sat(WW'($signed(dt_r[h*DW +: DW])) + WW'($signed(bias_r[h*DW +: DW])));
      dtp_v = s_v[DW-1] ? '0 : s_v;
      t_v   = WW'(ONE) + WW'(mul(dtp_v, $signed(a_r[h*DW +: DW])));
      if (t_v[WW-1])          da_v = '0;
      else if (t_v > WW'(ONE)) da_v = ONE;
      else                     da_v = t_v[DW-1:0];
      for (int p = 0; p < P_TILE; p++) begin
        k   = h * P_TILE + p;
        x_v = $signed(x_r[k*DW +: DW]);
        for (int n = 0; n < N_TILE; n++) begin
          hn_v = sat(WW'(mul(da_v, $signed(hp_r[(k*N_TILE+n)*DW +: DW]))) +
                     WW'(mul(mul(dtp_v, $signed(b_r[n*DW +: DW])), x_v)));
          tile_sum[k] = tile_sum[k] + AW'(mul(hn_v, $signed(c_r[n*DW +: DW])));
`ifdef SSM_HSTATE_OUT_EN
          hn_flat[(k*N_TILE+n)*DW +: DW] = hn_v;
`endif
        end
        y_next[k] = sat(WW'(acc[k]) + WW'(mul($signed(d_r[h*DW +: DW]), x_v)));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < HP; k++) acc[k] <= '0;
      tile_cnt        <= '0;
      y_final_o       <= '0;
      y_final_valid_o <= 1'b0;
    end else begin
      y_final_valid_o <= final_done;
      if (busy_done) begin
        for (int k = 0; k < HP; k++) acc[k] <= acc[k] + tile_sum[k];
        if (!last_tile) tile_cnt <= tile_cnt + 1'b1;
      end
      if (final_done) begin
        for (int k = 0; k < HP; k++) begin
          acc[k]                 <= '0;
          y_final_o[k*DW +: DW]  <= y_next[k];
        end
        tile_cnt <= '0;
      end
    end
  end

`ifdef SSM_HSTATE_OUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_new_o       <= '0;
      h_new_valid_o <= 1'b0;
    end else begin
      h_new_valid_o <= busy_done;
      if (busy_done) h_new_o <= hn_flat;
    end
  end
`endif

endmodule

// File: tb/tb_ssm_block_core.sv
// Bench for ssm_block_core: directed Q8.8 cases plus random tiles against a plain-arithmetic model.
module tb_ssm_block_core;
  localparam int DW = 16;
  localparam int N1 = 128;
  localparam int N2 = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance 1: default build (single tile per group)
  logic v1, r1, yv1;
  logic [DW-1:0] dt1, bias1, a1, x1, d1, y1;
  logic [N1*DW-1:0] b1, c1, h1;
  // Instance 2: N_TILE=64, two tiles per group
  logic v2, r2, yv2;
  logic [DW-1:0] dt2, bias2, a2, x2, d2, y2;
  logic [N2*DW-1:0] b2, c2, h2;
`ifdef SSM_HSTATE_OUT_EN
  logic [N1*DW-1:0] hn1;
  logic [N2*DW-1:0] hn2;
  logic hnv1, hnv2;
`endif

  ssm_block_core dut1 (
    .clk(clk), .rstn(rstn), .tile_valid_i(v1), .tile_ready_o(r1),
    .dt_i(dt1), .dt_bias_i(bias1), .A_i(a1), .x_i(x1), .D_i(d1),
    .B_tile_i(b1), .C_tile_i(c1), .hprev_tile_i(h1),
    .y_final_o(y1), .y_final_valid_o(yv1)
`ifdef SSM_HSTATE_OUT_EN
    , .h_new_o(hn1), .h_new_valid_o(hnv1)
`endif
  );

  ssm_block_core #(.N_TILE(N2)) dut2 (
    .clk(clk), .rstn(rstn), .tile_valid_i(v2), .tile_ready_o(r2),
    .dt_i(dt2), .dt_bias_i(bias2), .A_i(a2), .x_i(x2), .D_i(d2),
    .B_tile_i(b2), .C_tile_i(c2), .hprev_tile_i(h2),
    .y_final_o(y2), .y_final_valid_o(yv2)
`ifdef SSM_HSTATE_OUT_EN
    , .h_new_o(hn2), .h_new_valid_o(hnv2)
`endif
  );

  int checks = 0;
  int errors = 0;
  int t_acc  = 0;
  logic [DW-1:0] exp_q[$];

  int m_b[N1], m_c[N1], m_h[N1];
  int m_dt, m_bias, m_a, m_x, m_d;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic longint satl(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Q8.8 multiply: full product, floor-divide by 256, clamp
  function automatic longint mull(input longint a, input longint b);
    return satl((a * b) >>> 8);
  endfunction

  // Sum over n of hn*C for the tile currently held in the model arrays
  function automatic longint contrib(input int nn);
    longint s, dtp, da, hn, sum;
    s   = satl(longint'(m_dt) + longint'(m_bias));
    dtp = (s < 0) ? 0 : s;
    da  = 256 + mull(dtp, m_a);
    if (da < 0)   da = 0;
    if (da > 256) da = 256;
    sum = 0;
    for (int n = 0; n < nn; n++) begin
      hn  = satl(mull(da, m_h[n]) + mull(mull(dtp, m_b[n]), m_x));
      sum = sum + mull(hn, m_c[n]);
    end
    return sum;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic set_defaults();
    for (int n = 0; n < N1; n++) begin
      m_b[n] = 'h100; m_h[n] = 'h200; m_c[n] = 0;
    end
    m_c[0] = 'h100;
    m_dt = 'h100; m_bias = 0; m_a = -128; m_x = 'h100; m_d = 'h100;
  endtask

  task automatic randomize_tile();
    for (int n = 0; n < N1; n++) begin
      m_b[n] = rnd(-512, 511); m_h[n] = rnd(-1024, 1023); m_c[n] = rnd(-256, 255);
    end
    m_dt = rnd(-1024, 1023); m_bias = rnd(-256, 255); m_a = rnd(-512, 0);
    m_x = rnd(-512, 511); m_d = rnd(-512, 511);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the acceptance edge
  task automatic send(input int which, input bit hold);
    int waited;
    waited = 0;
    while (((which == 0) ? r1 : r2) !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 40) chk("ready_timeout", 0, 1);
    if (which == 0) begin
      for (int n = 0; n < N1; n++) begin
        b1[n*DW +: DW] = DW'(m_b[n]); c1[n*DW +: DW] = DW'(m_c[n]); h1[n*DW +: DW] = DW'(m_h[n]);
      end
      dt1 = DW'(m_dt); bias1 = DW'(m_bias); a1 = DW'(m_a); x1 = DW'(m_x); d1 = DW'(m_d);
      v1 = 1'b1;
    end else begin
      for (int n = 0; n < N2; n++) begin
        b2[n*DW +: DW] = DW'(m_b[n]); c2[n*DW +: DW] = DW'(m_c[n]); h2[n*DW +: DW] = DW'(m_h[n]);
      end
      dt2 = DW'(m_dt); bias2 = DW'(m_bias); a2 = DW'(m_a); x2 = DW'(m_x); d2 = DW'(m_d);
      v2 = 1'b1;
    end
    @(posedge clk); #1;
    t_acc = cyc;
    if (!hold) begin
      v1 = 1'b0;
      v2 = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int which, input int budget, output int lat,
                            output logic [DW-1:0] y, output int rdy_hi);
    lat = -1; y = '0; rdy_hi = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ((which == 0) ? yv1 : yv2) begin
        lat = cyc - t_acc;
        y   = (which == 0) ? y1 : y2;
        break;
      end
      if ((which == 0) ? r1 : r2) rdy_hi++;
    end
  endtask

  task automatic run1(input string tag, input bit hold, output logic [DW-1:0] y);
    int lat, rh;
    exp_q.push_back(DW'(satl(contrib(N1) + mull(m_d, m_x))));
    send(0, hold);
    wait_pulse(0, 400, lat, y, rh);
    chk({tag, "_rdy_in_pulse"}, r1, 0);
    v1 = 1'b0;
    chk({tag, "_lat"}, lat, 270);
    chk({tag, "_rdy_busy"}, rh, 0);
    chk({tag, "_y"}, y, exp_q.pop_front());
  endtask

  task automatic run2(input string tag, input bit rand_en, output logic [DW-1:0] y);
    int lat, rh;
    longint part;
    if (rand_en) randomize_tile();
    part = contrib(N2);
    send(1, 0);
    wait_pulse(1, 262, lat, y, rh);
    chk({tag, "_no_early_pulse"}, lat, -1);
    chk({tag, "_ready_between"}, r2, 1);
    if (rand_en) randomize_tile();
    exp_q.push_back(DW'(satl(part + contrib(N2) + mull(m_d, m_x))));
    send(1, 0);
    wait_pulse(1, 400, lat, y, rh);
    chk({tag, "_lat"}, lat, 270);
    chk({tag, "_y"}, y, exp_q.pop_front());
  endtask

  initial begin : main
    logic [DW-1:0] y;
    int lat, rh;
    v1 = 0; v2 = 0;
    dt1 = '0; bias1 = '0; a1 = '0; x1 = '0; d1 = '0; b1 = '0; c1 = '0; h1 = '0;
    dt2 = '0; bias2 = '0; a2 = '0; x2 = '0; d2 = '0; b2 = '0; c2 = '0; h2 = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", r1, 1);
    chk("reset_valid", yv1, 0);
    chk("reset_y", y1, 0);
    chk("reset_ready2", r2, 1);
    rstn = 1'b1;
    @(posedge clk); #1;

    set_defaults();
    run1("basic", 0, y);
    chk("basic_const", y, 'h0300);
    @(posedge clk); #1;
    chk("basic_ready_after", r1, 1);
    chk("basic_pulse_width", yv1, 0);
    chk("basic_y_hold", y1, 'h0300);

    set_defaults();
    m_dt = -512;
    run1("negdt", 0, y);
    chk("negdt_const", y, 'h0300);

    set_defaults();
    for (int n = 0; n < N1; n++) m_c[n] = 'h100;
    run1("sat", 0, y);
    chk("sat_const", y, 'h7FFF);

    set_defaults();
    m_dt = 'h0080;
    run1("hold", 1, y);
    repeat (20) @(posedge clk);
    #1;
    chk("hold_no_second_accept", r1, 1);

    set_defaults();
    send(0, 0);
    repeat (100) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_ready", r1, 1);
    chk("rst_valid", yv1, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_pulse(0, 300, lat, y, rh);
    chk("rst_no_pulse", lat, -1);
    chk("rst_idle_ready", r1, 1);

    set_defaults();
    run2("multi", 0, y);
    chk("multi_const", y, 'h0500);

    for (int i = 0; i < 6; i++) begin
      randomize_tile();
      run1($sformatf("rnd%0d", i), 0, y);
    end
    for (int i = 0; i < 2; i++) run2($sformatf("rndm%0d", i), 1, y);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
